// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch timekeeping datapath.
package stopwatch_pkg;

    // Counter terminal values
    localparam int unsigned MS10_MAX = 99;
    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    // Counter widths
    localparam int unsigned W_MS10 = 7;
    localparam int unsigned W_SEC  = 6;
    localparam int unsigned W_MIN  = 6;
    localparam int unsigned W_HOUR = 5;

    // Display page select, same encoding as the control FSM's change state
    localparam logic PAGE_MS10_SEC = 1'b0;
    localparam logic PAGE_MIN_HOUR = 1'b1;

    // Prescaler divide ratio; 0 flags an unusable configuration
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
        if (tick_hz == 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/sw_mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear and a combinational carry-out.
module sw_mod_counter #(
    parameter int unsigned MAX   = 9,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear beats increment; anything at or past MAX wraps to 0
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = (count_q >= MAX_VAL) ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign carry = inc && (count_q == MAX_VAL);

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch timekeeping datapath: 10 ms prescaler, cascaded ms10/sec/min/hour
// counters and the display page mux.
// Optional lap-hold display snapshot when STOPWATCH_LAP_EN is defined.
module stopwatch_datapath
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              change,
`ifdef STOPWATCH_LAP_EN
    input  logic              lap,
`endif
    output logic [W_MS10-1:0] ms10,
    output logic [W_SEC-1:0]  sec,
    output logic [W_MIN-1:0]  min,
    output logic [W_HOUR-1:0] hour,
    output logic [6:0]        disp_hi,
    output logic [6:0]        disp_lo,
    output logic              tick_10ms
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int unsigned PW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    if (DIV < 2 || (CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_bad_div
        $error("stopwatch_datapath: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          carry_ms10, carry_sec, carry_min, carry_hour;

    // Prescaler: counts only while enabled, so a pause keeps the partial tick
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (clear) begin
            presc_d = '0;
        end else if (enable) begin
            if (presc_q >= PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Prescaler and registered tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_10ms = tick_q;

    // A tick already issued is always consumed, even if enable drops right after it;
    // clear still wins inside each counter.
    sw_mod_counter #(.MAX(MS10_MAX), .WIDTH(W_MS10)) u_ms10 (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (tick_q),
        .count (ms10),
        .carry (carry_ms10)
    );

    sw_mod_counter #(.MAX(SEC_MAX), .WIDTH(W_SEC)) u_sec (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (carry_ms10),
        .count (sec),
        .carry (carry_sec)
    );

    sw_mod_counter #(.MAX(MIN_MAX), .WIDTH(W_MIN)) u_min (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (carry_sec),
        .count (min),
        .carry (carry_min)
    );

    sw_mod_counter #(.MAX(HOUR_MAX), .WIDTH(W_HOUR)) u_hour (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (carry_min),
        .count (hour),
        .carry (carry_hour)
    );

    logic [W_MS10-1:0] show_ms10;
    logic [W_SEC-1:0]  show_sec;
    logic [W_MIN-1:0]  show_min;
    logic [W_HOUR-1:0] show_hour;

`ifdef STOPWATCH_LAP_EN
    logic              lap_q, lap_d;
    logic [W_MS10-1:0] snap_ms10_q, snap_ms10_d;
    logic [W_SEC-1:0]  snap_sec_q, snap_sec_d;
    logic [W_MIN-1:0]  snap_min_q, snap_min_d;
    logic [W_HOUR-1:0] snap_hour_q, snap_hour_d;

    // Lap flag toggles on each pulse; snapshot is taken only when entering lap-hold
    always_comb begin
        lap_d       = lap_q;
        snap_ms10_d = snap_ms10_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        snap_hour_d = snap_hour_q;
        if (clear) begin
            lap_d       = 1'b0;
            snap_ms10_d = '0;
            snap_sec_d  = '0;
            snap_min_d  = '0;
            snap_hour_d = '0;
        end else if (lap) begin
            lap_d = ~lap_q;
            if (!lap_q) begin
                snap_ms10_d = ms10;
                snap_sec_d  = sec;
                snap_min_d  = min;
                snap_hour_d = hour;
            end
        end
    end

    // Lap flag and snapshot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q       <= 1'b0;
            snap_ms10_q <= '0;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            snap_hour_q <= '0;
        end else begin
            lap_q       <= lap_d;
            snap_ms10_q <= snap_ms10_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            snap_hour_q <= snap_hour_d;
        end
    end

    // Display source: frozen snapshot while in lap-hold, live counts otherwise
    always_comb begin
        show_ms10 = lap_q ? snap_ms10_q : ms10;
        show_sec  = lap_q ? snap_sec_q  : sec;
        show_min  = lap_q ? snap_min_q  : min;
        show_hour = lap_q ? snap_hour_q : hour;
    end
`else
    // Display source: always the live counts
    always_comb begin
        show_ms10 = ms10;
        show_sec  = sec;
        show_min  = min;
        show_hour = hour;
    end
`endif

    // Page mux; purely combinational so switching pages never touches a count
    always_comb begin
        disp_hi = {1'b0, show_sec};
        disp_lo = show_ms10;
        if (change == PAGE_MIN_HOUR) begin
            disp_hi = {2'b00, show_hour};
            disp_lo = {1'b0, show_min};
        end
    end

endmodule
